// File: rtl/ddr3_burst_writer_if.sv
// Bus bundle for the DDR3 burst writer: user beat channel plus the Avalon-MM write port.
// The slave modport is the writer's view; the master modport is the surrounding system's view.
interface ddr3_burst_writer_if #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 26
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic [DATA_W/8-1:0]   wr_be;

  logic                  ddr3_avl_ready;
  logic                  ddr3_avl_burstbegin;
  logic                  ddr3_avl_write_req;
  logic [3:0]            ddr3_avl_size;
  logic [ADDR_W-1:0]     ddr3_avl_addr;
  logic [DATA_W-1:0]     ddr3_avl_wr_data;
  logic [DATA_W/8-1:0]   ddr3_avl_be;

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_be, ddr3_avl_ready,
    output wr_ready, ddr3_avl_burstbegin, ddr3_avl_write_req, ddr3_avl_size,
           ddr3_avl_addr, ddr3_avl_wr_data, ddr3_avl_be
  );

  modport master (
    output wr_valid, wr_addr, wr_data, wr_be, ddr3_avl_ready,
    input  wr_ready, ddr3_avl_burstbegin, ddr3_avl_write_req, ddr3_avl_size,
           ddr3_avl_addr, ddr3_avl_wr_data, ddr3_avl_be
  );
endinterface

// File: rtl/ddr3_burst_writer.sv
// Buffers user write beats and issues them as fixed-length Avalon-MM bursts to a DDR3 controller.
// A beat leaves the buffer only when it transfers, so fifo_level counts every beat not yet written.
module ddr3_burst_writer #(
  parameter int DATA_W     = 128,
  parameter int ADDR_W     = 26,
  parameter int BURST_LEN  = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        ddr3_clk,
  input  logic                        reset_n,
  ddr3_burst_writer_if.slave          bus,
  output logic                        burst_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int BE_W    = DATA_W / 8;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int A_DEPTH = (FIFO_DEPTH / BURST_LEN < 1) ? 1 : FIFO_DEPTH / BURST_LEN;
  localparam int A_PTR_W = (A_DEPTH > 1) ? $clog2(A_DEPTH) : 1;
  localparam int A_LVL_W = $clog2(A_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BURST = 2'd1, S_DONE = 2'd2} state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
  } beat_t;

  state_e              state_q, state_d;
  logic                write_req, start, xfer, last_beat;
  logic                push, addr_push, beat_full, addr_full;

  beat_t               beat_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]   addr_mem [A_DEPTH];
  logic [PTR_W-1:0]    beat_wr_ptr_q, beat_rd_ptr_q, beat_rd_nxt;
  logic [LVL_W-1:0]    level_q;
  logic [A_PTR_W-1:0]  addr_wr_ptr_q, addr_rd_ptr_q;
  logic [A_LVL_W-1:0]  addr_lvl_q;
  logic [3:0]          grp_cnt_q, out_cnt_q;
  logic                first_q;
  logic [ADDR_W-1:0]   avl_addr_q;
  beat_t               avl_beat_q;

  function automatic logic [A_PTR_W-1:0] a_inc(input logic [A_PTR_W-1:0] p);
    return (p == A_PTR_W'(A_DEPTH - 1)) ? '0 : p + A_PTR_W'(1);
  endfunction

  // Input side: a group may only open when its address has somewhere to go.
  assign beat_full   = (level_q == LVL_W'(FIFO_DEPTH));
  assign addr_full   = (addr_lvl_q == A_LVL_W'(A_DEPTH));
  assign bus.wr_ready = !beat_full && ((grp_cnt_q != 4'd0) || !addr_full);
  assign push        = bus.wr_valid && bus.wr_ready;
  assign addr_push   = push && (grp_cnt_q == 4'd0);
  assign beat_rd_nxt = beat_rd_ptr_q + PTR_W'(1);
  assign last_beat   = (out_cnt_q == 4'(BURST_LEN - 1));
  assign xfer        = write_req && bus.ddr3_avl_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ddr3_clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start)             state_d = S_BURST;
      S_BURST: if (xfer && last_beat) state_d = S_DONE;
      S_DONE:                         state_d = S_IDLE;
      default:                        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    start      = 1'b0;
    write_req  = 1'b0;
    burst_done = 1'b0;
    unique case (state_q)
      S_IDLE:  start      = (level_q >= LVL_W'(BURST_LEN));
      S_BURST: write_req  = 1'b1;
      S_DONE:  burst_done = 1'b1;
      default: ;
    endcase
  end

  // NOTE: the storage arrays carry no reset; pointers and levels alone define which entries are valid.
  always_ff @(posedge ddr3_clk) begin
    if (push)      beat_mem[beat_wr_ptr_q] <= {bus.wr_data, bus.wr_be};
    if (addr_push) addr_mem[addr_wr_ptr_q] <= bus.wr_addr;
  end

  always_ff @(posedge ddr3_clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_wr_ptr_q <= '0;
      beat_rd_ptr_q <= '0;
      level_q       <= '0;
      addr_wr_ptr_q <= '0;
      addr_rd_ptr_q <= '0;
      addr_lvl_q    <= '0;
      grp_cnt_q     <= '0;
      out_cnt_q     <= '0;
      first_q       <= 1'b0;
      avl_addr_q    <= '0;
      avl_beat_q    <= '0;
    end else begin
      if (push) begin
        beat_wr_ptr_q <= beat_wr_ptr_q + PTR_W'(1);
        grp_cnt_q     <= last_grp_beat() ? 4'd0 : grp_cnt_q + 4'd1;
      end
      if (addr_push) addr_wr_ptr_q <= a_inc(addr_wr_ptr_q);
      if (start)     addr_rd_ptr_q <= a_inc(addr_rd_ptr_q);
      if (xfer)      beat_rd_ptr_q <= beat_rd_nxt;
      level_q    <= level_q + LVL_W'(push) - LVL_W'(xfer);
      addr_lvl_q <= addr_lvl_q + A_LVL_W'(addr_push) - A_LVL_W'(start);

      // The presented beat is the buffer head; on a transfer the one behind it is already resident.
      if (start) begin
        avl_addr_q <= addr_mem[addr_rd_ptr_q];
        avl_beat_q <= beat_mem[beat_rd_ptr_q];
        first_q    <= 1'b1;
        out_cnt_q  <= '0;
      end else if (xfer) begin
        first_q   <= 1'b0;
        out_cnt_q <= out_cnt_q + 4'd1;
        if (!last_beat) avl_beat_q <= beat_mem[beat_rd_nxt];
      end
    end
  end

  function automatic logic last_grp_beat();
    return grp_cnt_q == 4'(BURST_LEN - 1);
  endfunction

  assign bus.ddr3_avl_write_req  = write_req;
  assign bus.ddr3_avl_burstbegin = first_q;
  assign bus.ddr3_avl_size       = 4'(BURST_LEN);
  assign bus.ddr3_avl_addr       = avl_addr_q;
  assign bus.ddr3_avl_wr_data    = avl_beat_q.data;
  assign bus.ddr3_avl_be         = avl_beat_q.be;
  assign fifo_level              = level_q;
endmodule

// File: tb/tb_ddr3_burst_writer.sv
// Self-checking bench for ddr3_burst_writer: directed burst scenarios plus randomized traffic,
// scored against a transaction-level model of grouped beats and expected Avalon transfers.
module tb_ddr3_burst_writer;
  localparam int DATA_W     = 128;
  localparam int ADDR_W     = 26;
  localparam int BURST_LEN  = 4;
  localparam int FIFO_DEPTH = 16;
  localparam int BE_W       = DATA_W / 8;

  logic                        ddr3_clk;
  logic                        reset_n;
  logic                        burst_done;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;

  int n_checks = 0;
  int n_errors = 0;

  ddr3_burst_writer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  ddr3_burst_writer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .ddr3_clk  (ddr3_clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .burst_done(burst_done),
    .fifo_level(fifo_level)
  );

  initial ddr3_clk = 1'b0;
  always #5 ddr3_clk = ~ddr3_clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: beats collected into groups of BURST_LEN; a complete group becomes
  // BURST_LEN expected transfers, all carrying the address seen on the group's first beat.
  typedef struct {
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    bit                first;
  } exp_t;

  exp_t              exp_q[$];
  logic [DATA_W-1:0] grp_data [BURST_LEN];
  logic [BE_W-1:0]   grp_be   [BURST_LEN];
  logic [ADDR_W-1:0] grp_addr;
  int                in_cnt, out_cnt_m, level_m, bursts_seen;
  bit                done_due, stall_prev;
  logic [DATA_W-1:0] prev_data;
  logic [BE_W-1:0]   prev_be;
  logic [ADDR_W-1:0] prev_addr;

  always @(negedge ddr3_clk) begin
    if (!reset_n) begin
      exp_q.delete();
      in_cnt = 0; out_cnt_m = 0; level_m = 0;
      done_due = 0; stall_prev = 0;
    end else begin
      check("level", 128'(fifo_level), 128'(level_m));
      if (done_due || burst_done) check("burst_done", 128'(burst_done), 128'(done_due));
      if (burst_done) begin
        bursts_seen++;
        check("req_in_done", 128'(bus.ddr3_avl_write_req), 128'(0));
      end
      if (stall_prev) begin
        check("stall_req",  128'(bus.ddr3_avl_write_req), 128'(1));
        check("stall_data", 128'(bus.ddr3_avl_wr_data), 128'(prev_data));
        check("stall_be",   128'(bus.ddr3_avl_be), 128'(prev_be));
        check("stall_addr", 128'(bus.ddr3_avl_addr), 128'(prev_addr));
      end
      done_due = 0;

      if (bus.ddr3_avl_write_req && bus.ddr3_avl_ready) begin
        if (exp_q.size() == 0) begin
          check("xfer_unexpected", 128'(1), 128'(0));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("xfer_data",  128'(bus.ddr3_avl_wr_data), 128'(e.data));
          check("xfer_be",    128'(bus.ddr3_avl_be), 128'(e.be));
          check("xfer_addr",  128'(bus.ddr3_avl_addr), 128'(e.addr));
          check("xfer_begin", 128'(bus.ddr3_avl_burstbegin), 128'(e.first));
        end
        level_m--;
        out_cnt_m++;
        if (out_cnt_m == BURST_LEN) begin
          out_cnt_m = 0;
          done_due  = 1;
        end
      end
      stall_prev = bus.ddr3_avl_write_req && !bus.ddr3_avl_ready;
      prev_data  = bus.ddr3_avl_wr_data;
      prev_be    = bus.ddr3_avl_be;
      prev_addr  = bus.ddr3_avl_addr;

      if (bus.wr_valid && bus.wr_ready) begin
        if (in_cnt == 0) grp_addr = bus.wr_addr;
        grp_data[in_cnt] = bus.wr_data;
        grp_be[in_cnt]   = bus.wr_be;
        in_cnt++;
        level_m++;
        if (in_cnt == BURST_LEN) begin
          for (int k = 0; k < BURST_LEN; k++)
            exp_q.push_back('{data: grp_data[k], be: grp_be[k], addr: grp_addr, first: (k == 0)});
          in_cnt = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge ddr3_clk);
    #1;
  endtask

  task automatic push_beat(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           input logic [BE_W-1:0] b, input int limit);
    bit accepted = 0;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    bus.wr_be    = b;
    for (int i = 0; i < limit && !accepted; i++) begin
      @(negedge ddr3_clk);
      accepted = bus.wr_ready;
      step();
    end
    bus.wr_valid = 1'b0;
    if (!accepted) check("push_timeout", 128'(0), 128'(1));
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic wait_write_req(input int limit);
    bit seen = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge ddr3_clk);
      seen = bus.ddr3_avl_write_req;
    end
    if (!seen) check("write_req_timeout", 128'(0), 128'(1));
  endtask

  task automatic wait_drain(input int limit);
    bit idle = 0;
    for (int i = 0; i < limit && !idle; i++) begin
      @(negedge ddr3_clk);
      idle = (exp_q.size() == 0) && !bus.ddr3_avl_write_req && !burst_done;
    end
    if (!idle) check("drain_timeout", 128'(0), 128'(1));
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  bit push_done;

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.wr_be    = '0;
    bus.ddr3_avl_ready = 1'b1;
    reset_n = 1'b0;
    bursts_seen = 0;
    repeat (3) step();

    check("rst_write_req", 128'(bus.ddr3_avl_write_req), 128'(0));
    check("rst_begin",     128'(bus.ddr3_avl_burstbegin), 128'(0));
    check("rst_done",      128'(burst_done), 128'(0));
    check("rst_addr",      128'(bus.ddr3_avl_addr), 128'(0));
    check("rst_data",      128'(bus.ddr3_avl_wr_data), 128'(0));
    check("rst_be",        128'(bus.ddr3_avl_be), 128'(0));
    check("rst_level",     128'(fifo_level), 128'(0));
    check("rst_size",      128'(bus.ddr3_avl_size), 128'(BURST_LEN));
    reset_n = 1'b1;
    @(negedge ddr3_clk);
    check("rst_wr_ready", 128'(bus.wr_ready), 128'(1));
    step();

    // Single burst at 0x100, data 1..4; later beats carry junk addresses that must be ignored.
    for (int i = 1; i <= 4; i++)
      push_beat((i == 1) ? ADDR_W'('h100) : ADDR_W'($urandom), DATA_W'(i), '1, 20);
    wait_drain(50);
    check("t1_bursts", 128'(bursts_seen), 128'(1));

    // Partial group stays buffered until its last beat arrives.
    for (int i = 0; i < 3; i++) push_beat(ADDR_W'($urandom), rand_data(), BE_W'($urandom), 20);
    repeat (10) step();
    @(negedge ddr3_clk);
    check("partial_no_req", 128'(bus.ddr3_avl_write_req), 128'(0));
    check("partial_level",  128'(fifo_level), 128'(3));
    step();
    push_beat(ADDR_W'($urandom), rand_data(), BE_W'($urandom), 20);
    wait_drain(50);
    check("t2_bursts", 128'(bursts_seen), 128'(2));

    // Slave stalls for 5 cycles while beat 2 is presented.
    bus.ddr3_avl_ready = 1'b0;
    for (int i = 1; i <= 4; i++)
      push_beat((i == 1) ? ADDR_W'('h200) : ADDR_W'($urandom), DATA_W'(i), '1, 20);
    wait_write_req(20);
    step();
    bus.ddr3_avl_ready = 1'b1;
    step();
    bus.ddr3_avl_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge ddr3_clk);
      check("stall2_req",   128'(bus.ddr3_avl_write_req), 128'(1));
      check("stall2_data",  128'(bus.ddr3_avl_wr_data), 128'(2));
      check("stall2_addr",  128'(bus.ddr3_avl_addr), 128'('h200));
      check("stall2_begin", 128'(bus.ddr3_avl_burstbegin), 128'(0));
      step();
    end
    bus.ddr3_avl_ready = 1'b1;
    wait_drain(50);
    check("t3_bursts", 128'(bursts_seen), 128'(3));

    // Fill to capacity with the slave blocked, then drain five bursts in order.
    bus.ddr3_avl_ready = 1'b0;
    for (int i = 0; i < 16; i++) push_beat(ADDR_W'($urandom), rand_data(), BE_W'($urandom), 5);
    begin
      logic [ADDR_W-1:0] a17 = ADDR_W'($urandom);
      logic [DATA_W-1:0] d17 = rand_data();
      logic [BE_W-1:0]   b17 = BE_W'($urandom);
      bus.wr_valid = 1'b1;
      bus.wr_addr  = a17;
      bus.wr_data  = d17;
      bus.wr_be    = b17;
      for (int i = 0; i < 5; i++) begin
        @(negedge ddr3_clk);
        check("full_wr_ready", 128'(bus.wr_ready), 128'(0));
        check("full_level",    128'(fifo_level), 128'(16));
        step();
      end
      bus.ddr3_avl_ready = 1'b1;
      push_beat(a17, d17, b17, 40);
    end
    for (int i = 0; i < 3; i++) push_beat(ADDR_W'($urandom), rand_data(), BE_W'($urandom), 40);
    wait_drain(200);
    check("t4_bursts", 128'(bursts_seen), 128'(8));

    // Continuous random traffic across pointer wrap, starting near full.
    push_done = 0;
    fork
      begin
        for (int b = 0; b < 48; b++) begin
          if ($urandom_range(3) == 0) step();
          push_beat(ADDR_W'($urandom), rand_data(), BE_W'($urandom), 200);
        end
        push_done = 1;
      end
      begin
        for (int c = 0; !push_done; c++) begin
          bus.ddr3_avl_ready = (c < 14) ? 1'b0 : 1'($urandom_range(1));
          step();
        end
      end
    join
    bus.ddr3_avl_ready = 1'b1;
    wait_drain(400);
    check("t5_bursts", 128'(bursts_seen), 128'(20));

    // Reset mid-burst after beat 2 abandons the burst and empties the buffer.
    bus.ddr3_avl_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_beat(ADDR_W'($urandom), rand_data(), BE_W'($urandom), 20);
    wait_write_req(20);
    step();
    bus.ddr3_avl_ready = 1'b1;
    step();
    step();
    bus.ddr3_avl_ready = 1'b0;
    reset_n = 1'b0;
    #1;
    check("mid_rst_req",   128'(bus.ddr3_avl_write_req), 128'(0));
    check("mid_rst_begin", 128'(bus.ddr3_avl_burstbegin), 128'(0));
    check("mid_rst_done",  128'(burst_done), 128'(0));
    check("mid_rst_addr",  128'(bus.ddr3_avl_addr), 128'(0));
    check("mid_rst_data",  128'(bus.ddr3_avl_wr_data), 128'(0));
    check("mid_rst_be",    128'(bus.ddr3_avl_be), 128'(0));
    check("mid_rst_level", 128'(fifo_level), 128'(0));
    step();
    reset_n = 1'b1;
    @(negedge ddr3_clk);
    check("post_rst_ready", 128'(bus.wr_ready), 128'(1));
    check("post_rst_req",   128'(bus.ddr3_avl_write_req), 128'(0));
    step();
    bus.ddr3_avl_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_beat(ADDR_W'($urandom), rand_data(), BE_W'($urandom), 20);
    wait_drain(50);
    check("t6_bursts", 128'(bursts_seen), 128'(21));

    check("end_exp_empty", 128'(exp_q.size()), 128'(0));
    check("end_size",      128'(bus.ddr3_avl_size), 128'(BURST_LEN));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
